// File: rtl/cam_pkg.sv
// Shared sizing constants for the 16x16 content-addressable memory.
package cam_pkg;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: hit vector in, index of lowest set bit and any-hit flag out.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int N = DEPTH,
    parameter int W = ADDR_W
) (
    input  logic [N-1:0] hit,
    output logic         any_hit,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one assigned.
    always_comb begin
        any_hit = |hit;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/cam.sv
// Append-only CAM with registered search results and duplicate suppression on write.
module cam #(
    parameter int DATA_W = cam_pkg::DATA_W,
    parameter int DEPTH  = cam_pkg::DEPTH,
    parameter int ADDR_W = cam_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] DIN,
    input  logic              EN,
    input  logic              WE,
    output logic              match,
    output logic [ADDR_W-1:0] match_addr
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W:0]   wptr;
    logic [DEPTH-1:0]  hit;
    logic              any_hit;
    logic [ADDR_W-1:0] hit_idx;
    logic              full;
    logic              do_write;

    assign full     = (wptr == (ADDR_W + 1)'(DEPTH));
    assign do_write = EN && WE && !any_hit && !full;

    // Compare against contents as they stood before this edge's write.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (mem[i] == DIN);
        end
    end

    cam_prio_enc #(
        .N (DEPTH),
        .W (ADDR_W)
    ) u_prio_enc (
        .hit     (hit),
        .any_hit (any_hit),
        .idx     (hit_idx)
    );

    always_ff @(posedge clk) begin
        if (do_write) mem[wptr[ADDR_W-1:0]] <= DIN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid      <= '0;
            wptr       <= '0;
            match      <= 1'b0;
            match_addr <= '0;
        end else if (EN) begin
            match      <= any_hit;
            match_addr <= any_hit ? hit_idx : '0;
            if (do_write) begin
                valid[wptr[ADDR_W-1:0]] <= 1'b1;
                wptr                    <= wptr + 1'b1;
            end
        end else begin
            match      <= 1'b0;
            match_addr <= '0;
        end
    end

endmodule

// File: tb/tb_cam.sv
// Scoreboard bench for cam: a queue-of-words reference model predicts every registered result.
module tb_cam;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        en;
    logic        we;
    logic        match;
    logic [3:0]  match_addr;

    typedef struct {
        logic       m;
        logic [3:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_q[$];
    int          checks;
    int          errors;

    cam dut (
        .clk        (clk),
        .reset      (reset),
        .DIN        (din),
        .EN         (en),
        .WE         (we),
        .match      (match),
        .match_addr (match_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle at the falling edge and queue the result the model predicts.
    task automatic applyStimulus(input logic e, input logic w, input logic [15:0] d);
        exp_t x;
        int   found;
        @(negedge clk);
        en  = e;
        we  = w;
        din = d;
        found = -1;
        for (int i = 0; i < model_q.size(); i++) begin
            if (found < 0 && model_q[i] == d) found = i;
        end
        x.d = d;
        if (!e) begin
            x.m = 1'b0;
            x.a = 4'd0;
        end else begin
            x.m = (found >= 0);
            x.a = (found >= 0) ? 4'(found) : 4'd0;
            if (w && found < 0 && model_q.size() < 16) model_q.push_back(d);
        end
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are registered every edge, so each edge retires one prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput($sformatf("match din=%04h", x.d), int'(match), int'(x.m));
                checkOutput($sformatf("match_addr din=%04h", x.d), int'(match_addr), int'(x.a));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        en     = 1'b0;
        we     = 1'b0;
        din    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset match", int'(match), 0);
        checkOutput("reset match_addr", int'(match_addr), 0);
        reset = 1'b1;

        // Empty CAM, then basic insert and lookup.
        applyStimulus(1, 0, 16'h0001);
        applyStimulus(1, 1, 16'h0001);
        applyStimulus(1, 1, 16'h0002);
        applyStimulus(1, 1, 16'h0004);
        applyStimulus(1, 0, 16'h0004);
        applyStimulus(1, 0, 16'h0003);

        // Duplicate write is suppressed; next new word takes the following address.
        applyStimulus(1, 1, 16'h0005);
        applyStimulus(1, 1, 16'h0006);
        applyStimulus(1, 1, 16'h0007);
        applyStimulus(1, 1, 16'h0007);
        applyStimulus(1, 1, 16'h0009);
        applyStimulus(1, 0, 16'h0009);

        // Fill to capacity, then overflow writes are dropped.
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 16'h0010 + 16'(i));
        applyStimulus(1, 1, 16'h0030);
        applyStimulus(1, 0, 16'h0030);
        applyStimulus(1, 0, 16'h0001);
        applyStimulus(1, 0, 16'h001A);
        applyStimulus(1, 1, 16'h0002);

        // Asynchronous reset between edges while match is high.
        applyStimulus(1, 0, 16'h0004);
        @(posedge clk);
        #3;
        en = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("async reset match", int'(match), 0);
        checkOutput("async reset match_addr", int'(match_addr), 0);
        model_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 0, 16'h0004);
        applyStimulus(1, 1, 16'hABCD);
        applyStimulus(1, 0, 16'hABCD);

        // Enable gating: no result, no write, WE ignored.
        applyStimulus(0, 1, 16'hABCD);
        applyStimulus(0, 1, 16'h1234);
        applyStimulus(1, 0, 16'h1234);
        applyStimulus(1, 1, 16'h5555);
        applyStimulus(1, 0, 16'h5555);

        // Random traffic from a small word pool so hits, dups and overflow all occur.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0), $urandom_range(0, 1), 16'($urandom_range(0, 23)));
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
